// File: rtl/trace_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : trace_pkg                                                |
// | Description : Shared types for the contract-trace queue: queue entry,  |
// |               checker state encoding and occupancy-width helpers.      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package trace_pkg;

   // Stored address field is fixed-width; the top zero-extends AW into it,
   // so AW up to TRACE_ADDR_W is supported.
   localparam int TRACE_ADDR_W = 64;

   // Default queue depth and the matching occupancy width.
   localparam int TRACE_DEPTH = 8;
   localparam int CNT_W       = $clog2(TRACE_DEPTH + 1);

   // Occupancy counter width for an arbitrary depth (counts 0..depth).
   function automatic int trace_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // One contract observation pushed by the ISA pair.
   typedef struct packed {
      logic                    agree;
      logic                    mem_valid;
      logic [TRACE_ADDR_W-1:0] addr;
   } trace_entry_t;

   // Checker state: RUN checks, BROKEN means the contract itself split,
   // LEAK means the implementation diverged under an equal contract.
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      BROKEN = 2'd1,
      LEAK   = 2'd2
   } trace_state_e;

endpackage : trace_pkg
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : trace_fifo                                               |
// | Description : Synchronous FIFO with registered occupancy, full/empty   |
// |               and no write-to-read bypass. Pushes while full and pops  |
// |               while empty are ignored.                                 |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module trace_fifo
   import trace_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_push,
   input  logic                          i_pop,
   input  logic [W-1:0]                  i_push_data,
   output logic [W-1:0]                  o_pop_data,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [$clog2(DEPTH+1)-1:0]    o_count
);

   localparam int c_PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNT_W = trace_cnt_w(DEPTH);

   logic [W-1:0]       r_mem [DEPTH];
   logic [c_PW-1:0]    r_wr_ptr;
   logic [c_PW-1:0]    r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic               w_push_ok;
   logic               w_pop_ok;

   assign o_full     = (r_count == c_CNT_W'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;
   assign o_pop_data = r_mem[r_rd_ptr];
   assign w_push_ok  = i_push && !o_full;
   assign w_pop_ok   = i_pop && !o_empty;

   // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
         if (w_push_ok && !w_pop_ok)      r_count <= r_count + c_CNT_W'(1);
         else if (w_pop_ok && !w_push_ok) r_count <= r_count - c_CNT_W'(1);
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule : trace_fifo
`default_nettype wire

// File: rtl/contract_trace_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : contract_trace_queue                                     |
// | Description : Contract-trace bridge for four-copy leakage checking.    |
// |               ISA pair pushes one observation per retirement; the      |
// |               implementation pair pops one per commit and is checked   |
// |               copy-vs-copy. Latched leak verdict, underflow flag and   |
// |               ISA backpressure are all registered.                     |
// |               Optional macro TRACE_ADDR_CHECK_EN: store the ISA dmem   |
// |               address and compare it against implementation copy 1 on  |
// |               every pop of a memory-accessing entry.                   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module contract_trace_queue
   import trace_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       isa_commit_i,
   input  logic                       isa_mem_valid_i,
   input  logic [AW-1:0]              isa_addr1_i,
   input  logic [AW-1:0]              isa_addr2_i,
   input  logic [DW-1:0]              isa_wdata1_i,
   input  logic [DW-1:0]              isa_wdata2_i,
   output logic                       isa_stall_o,
   input  logic                       impl_commit1_i,
   input  logic                       impl_commit2_i,
   input  logic [AW-1:0]              impl_addr1_i,
   input  logic [AW-1:0]              impl_addr2_i,
   output logic                       contract_eq_o,
   output logic                       leak_o,
   output logic                       underflow_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int c_CNT_W = trace_cnt_w(DEPTH);

   trace_state_e       r_state;
   logic               r_stall;
   logic               r_contract_eq;
   logic               r_leak;
   logic               r_underflow;

   logic               w_full;
   logic               w_empty;
   logic [c_CNT_W-1:0] w_count;
   logic [c_CNT_W-1:0] w_count_nxt;
   logic               w_agree;
   logic               w_push;
   logic               w_pop_req;
   logic               w_pop;
   logic               w_underflow_evt;
   logic               w_diverge;
   logic               w_pop_agree;
   logic               w_addr_bad;
   logic               w_bad_push;
   logic               w_leak_evt;

   // ISA copies agree when writeback matches and, for memory ops, addresses match.
   assign w_agree = (isa_wdata1_i == isa_wdata2_i) &&
                    (!isa_mem_valid_i || (isa_addr1_i == isa_addr2_i));

   // Room in the queue is equivalent to !isa_stall_o; LEAK freezes both sides.
   assign w_push          = isa_commit_i && !w_full && (r_state != LEAK);
   assign w_pop_req       = impl_commit1_i && impl_commit2_i;
   assign w_pop           = w_pop_req && !w_empty && (r_state != LEAK);
   assign w_underflow_evt = w_pop_req && w_empty && (r_state != LEAK);
   assign w_diverge       = (impl_commit1_i != impl_commit2_i) ||
                            (impl_addr1_i != impl_addr2_i);

`ifdef TRACE_ADDR_CHECK_EN
   localparam int c_EW = $bits(trace_entry_t);
   trace_entry_t    w_push_entry;
   trace_entry_t    w_pop_entry;
   logic [c_EW-1:0] w_push_data;
   logic [c_EW-1:0] w_pop_data;

   // Full entry: agree bit plus the copy-1 address for functional comparison.
   always_comb begin
      w_push_entry           = '0;
      w_push_entry.agree     = w_agree;
      w_push_entry.mem_valid = isa_mem_valid_i;
      w_push_entry.addr      = TRACE_ADDR_W'(isa_addr1_i);
   end

   assign w_push_data = w_push_entry;
   assign w_pop_entry = trace_entry_t'(w_pop_data);
   assign w_pop_agree = w_pop_entry.agree;
   assign w_addr_bad  = w_pop && w_pop_entry.mem_valid &&
                        (TRACE_ADDR_W'(impl_addr1_i) != w_pop_entry.addr);
`else
   localparam int c_EW = 1;
   logic [c_EW-1:0] w_push_data;
   logic [c_EW-1:0] w_pop_data;

   assign w_push_data = w_agree;
   assign w_pop_agree = w_pop_data[0];
   assign w_addr_bad  = 1'b0;
`endif

   // A pop requires both commits, so the commits already agree on any pop.
   assign w_bad_push = w_push && !w_agree;
   assign w_leak_evt = w_diverge || (w_pop && !w_pop_agree) || w_addr_bad;

   trace_fifo #(
      .DEPTH (DEPTH),
      .W     (c_EW)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_push_data (w_push_data),
      .o_pop_data  (w_pop_data),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_count)
   );

   // Next occupancy, used to register the stall so it rises with count_o.
   always_comb begin
      w_count_nxt = w_count;
      if (w_push && !w_pop)      w_count_nxt = w_count + c_CNT_W'(1);
      else if (w_pop && !w_push) w_count_nxt = w_count - c_CNT_W'(1);
   end

   // Checker FSM with its registered verdict, underflow and stall outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= RUN;
         r_stall       <= 1'b0;
         r_contract_eq <= 1'b1;
         r_leak        <= 1'b0;
         r_underflow   <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               // A split contract covers the whole cycle, so it outranks divergence.
               if (w_bad_push) begin
                  r_state       <= BROKEN;
                  r_contract_eq <= 1'b0;
               end else if (w_leak_evt) begin
                  r_state <= LEAK;
                  r_leak  <= 1'b1;
               end
            end
            default: ;
         endcase
         if (w_underflow_evt) r_underflow <= 1'b1;
         r_stall <= (w_count_nxt == c_CNT_W'(DEPTH)) || (r_state == LEAK) ||
                    ((r_state == RUN) && !w_bad_push && w_leak_evt);
      end
   end

   assign isa_stall_o   = r_stall;
   assign contract_eq_o = r_contract_eq;
   assign leak_o        = r_leak;
   assign underflow_o   = r_underflow;
   assign count_o       = w_count;

endmodule : contract_trace_queue
`default_nettype wire

// File: doc/contract_trace_queue.md
# contract_trace_queue

Contract-trace producer/consumer bridge for four-copy leakage checking of the Sodor cores. The ISA-side pair (single-cycle reference cores) pushes one contract-observation entry per lockstep retirement. The implementation-side pair (2-stage cores) pops one entry per commit and compares its own commit and memory-address observations. Output is a latched leak verdict that a formal harness asserts low, plus a backpressure signal that clock-gates the ISA pair when the queue is full.

## Interface
Parameters:
- DEPTH, 8, queue entries; power of two, ≥2
- AW, 32, address width
- DW, 32, writeback-data width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- isa_commit_i  in  1  both ISA copies retire this cycle (lockstep)
- isa_mem_valid_i  in  1  retiring ISA instruction accesses dmem
- isa_addr1_i, isa_addr2_i  in  AW  ISA dmem addresses, copy 1/2
- isa_wdata1_i, isa_wdata2_i  in  DW  ISA writeback data, copy 1/2
- isa_stall_o  out  1  queue full; ISA copies hold
- impl_commit1_i, impl_commit2_i  in  1  implementation copy 1/2 commit valid
- impl_addr1_i, impl_addr2_i  in  AW  implementation dmem address; 0 when no request
- contract_eq_o  out  1  every pushed entry had ISA agreement
- leak_o  out  1  sticky; implementation divergence under equal contract
- underflow_o  out  1  sticky; implementation commit with empty queue
- count_o  out  $clog2(DEPTH+1)  occupancy

## Operation
- Push: isa_commit_i && !isa_stall_o.
  - Entry agree bit = (wdata1==wdata2) && (!isa_mem_valid_i || addr1==addr2).
  - Entry also holds isa_mem_valid_i and addr1.
- Pop: impl_commit1_i && impl_commit2_i && count_o!=0.
- No push-to-pop bypass. A pop request on an empty queue is not performed; it sets underflow_o.
- Divergence event in a cycle: impl_commit1_i != impl_commit2_i, or impl_addr1_i != impl_addr2_i.
- FSM, states RUN, BROKEN, LEAK; reset state RUN.
  - RUN -> BROKEN: a pushed entry has agree=0. contract_eq_o falls; checking stops.
  - RUN -> LEAK: a divergence event occurs, or a popped entry has agree=0 while impl commits agree.
  - BROKEN and LEAK are absorbing until rst.
  - If a push with agree=0 and a divergence event occur in the same cycle, BROKEN wins: the contract covers that cycle.
- In LEAK, the queue freezes: no push, no pop, isa_stall_o=1.
- Occupancy: count_o increments on push-only, decrements on pop-only, and is unchanged on push+pop. Pointers wrap modulo DEPTH.
- Full (count_o==DEPTH) with a pop in the same cycle: the push is still blocked that cycle, because stall derives from registered count.

## Timing
- All outputs are registered.
- Reset values: isa_stall_o=0, contract_eq_o=1, leak_o=0, underflow_o=0, count_o=0, FSM=RUN, pointers 0.
- Reset mid-operation discards all entries in the next cycle; sticky flags clear.
- leak_o and underflow_o rise 1 cycle after the offending cycle.
- contract_eq_o falls 1 cycle after the offending push.
- isa_stall_o = (count_o==DEPTH) || FSM==LEAK, registered. It rises the cycle after the DEPTH-th push.
- Push-to-pop latency is at least 1 cycle.

## Configuration
- TRACE_ADDR_CHECK_EN defined:
  - A pop also compares impl_addr1_i against the stored addr1 when the entry's mem_valid=1.
  - On a mismatch in RUN, the FSM moves to LEAK; this is a functional-divergence check.
- TRACE_ADDR_CHECK_EN undefined:
  - addr1 and mem_valid are not stored; entry width is 1 bit.
  - Only copy-vs-copy checks apply.

## Structure
- Package trace_pkg holds:
  - trace_entry_t struct (agree, mem_valid, addr)
  - trace_state_e enum (RUN, BROKEN, LEAK)
  - localparam CNT_W
- Sub-module trace_fifo: a parameterized synchronous FIFO with push/pop/full/empty/count and no bypass. The top-level wraps it with the FSM and comparators.

## Test plan
- Four pushes with equal data and addr 0x100 on both copies, then four pops with equal commits and addr 0x100 -> count returns to 0; leak_o=0; contract_eq_o=1.
- Eight pushes with no pops (DEPTH=8) -> isa_stall_o=1 the cycle after the 8th push. A ninth push is ignored; count_o stays 8. One pop -> count_o=7; stall drops the next cycle.
- Push with wdata1=5, wdata2=6 -> contract_eq_o=0 next cycle. A later pop with impl_addr1=0x10, impl_addr2=0x20 -> leak_o stays 0.
- One push with agree=1, then impl_commit1=1, impl_commit2=0 -> leak_o=1 next cycle and stays 1. isa_stall_o=1; count_o frozen at 1.
- Pop request (both impl commits high) on an empty queue -> underflow_o=1 next cycle; count_o stays 0. A rst pulse clears underflow_o to 0.
- With TRACE_ADDR_CHECK_EN: push mem_valid=1, addr 0x40; pop with both impl addrs at 0x44 -> leak_o=1. Without the macro, the same stimulus -> leak_o=0.
